// File: rtl/mem2io_ws_if.sv
// Host-side access bus between the SLC-3 state controller (MAR/MDR) and the
// memory/I-O bridge: request/write/address/data in, read data and status back.
interface mem2io_ws_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;

    modport master (output req, we, addr, wdata, input  rdata, ready, busy);
    modport slave  (input  req, we, addr, wdata, output rdata, ready, busy);
endinterface

// File: rtl/mem2io_ws.sv
// Memory/I-O bridge: top 16-word page decodes to hex/LED/switch registers,
// everything else goes to SRAM with WAIT_STATES extra cycles per access.
module mem2io_ws #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                NUM_HEX     = 8,
    parameter int                LED_W       = 10,
    parameter int                SW_W        = 10,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFFF0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mem2io_ws_if.slave           bus,
    input  logic [SW_W-1:0]      Switches,
    output logic [4*NUM_HEX-1:0] hex_digits,
    output logic [LED_W-1:0]     LED,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    Data_to_SRAM,
    input  logic [DATA_W-1:0]    Data_from_SRAM,
    output logic                 OE_N,
    output logic                 WE_N
);
    localparam int         HEX_WORDS = NUM_HEX / 4;
    localparam logic [3:0] LED_OFS   = 4'h8;
    localparam logic [3:0] SW_OFS    = 4'hF;

    typedef enum logic [1:0] {IDLE, SRAM_ACC, IO_ACC, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          wait_cnt, wait_cnt_nxt;
    logic                accept, io_hit, we_nxt, oe_n_nxt, we_n_nxt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata, rdata_q, io_rdata;
    logic [4*NUM_HEX-1:0] hex_q;
    logic [LED_W-1:0]    led_q;
    logic [SW_W-1:0]     sw_meta, sw_sync;
    logic [3:0]          offset;

    assign io_hit = (bus.addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign offset = lat_addr[3:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (io_hit) begin
                        state_nxt = IO_ACC;
                    end else begin
                        state_nxt    = SRAM_ACC;
                        wait_cnt_nxt = 4'(WAIT_STATES);
                    end
                end
            end
            SRAM_ACC: begin
                if (wait_cnt == 4'd0) state_nxt = DONE;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            IO_ACC:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Strobes are registered from the next state so they are glitch-free.
        we_nxt   = accept ? bus.we : lat_we;
        oe_n_nxt = !((state_nxt == SRAM_ACC) && !we_nxt);
        we_n_nxt = !((state_nxt == SRAM_ACC) &&  we_nxt);
    end

    always_comb begin
        io_rdata = '0;
        for (int n = 0; n < HEX_WORDS; n++) begin
            if (offset == 4'(n)) io_rdata[15:0] = hex_q[16*n +: 16];
        end
        if (offset == LED_OFS) io_rdata[LED_W-1:0] = led_q;
        if (offset == SW_OFS)  io_rdata[SW_W-1:0]  = sw_sync;
    end

    // NOTE: clocked blocks use <= only, so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            hex_q     <= '0;
            led_q     <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            OE_N      <= 1'b1;
            WE_N      <= 1'b1;
        end else begin
            OE_N    <= oe_n_nxt;
            WE_N    <= we_n_nxt;
            sw_meta <= Switches;
            sw_sync <= sw_meta;
            if (accept) begin
                lat_we    <= bus.we;
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
            end
            if (state == SRAM_ACC && wait_cnt == 4'd0 && !lat_we) rdata_q <= Data_from_SRAM;
            if (state == IO_ACC) begin
                if (lat_we) begin
                    for (int n = 0; n < HEX_WORDS; n++) begin
                        if (offset == 4'(n)) hex_q[16*n +: 16] <= lat_wdata[15:0];
                    end
                    // Offset 15 is the legacy 0xFFFF display word.
                    if (offset == SW_OFS)  hex_q[15:0] <= lat_wdata[15:0];
                    if (offset == LED_OFS) led_q       <= lat_wdata[LED_W-1:0];
                end else begin
                    rdata_q <= io_rdata;
                end
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ready    = (state == DONE);
    assign bus.busy     = (state != IDLE);
    assign hex_digits   = hex_q;
    assign LED          = led_q;
    assign sram_addr    = lat_addr;
    assign Data_to_SRAM = lat_wdata;
endmodule
